// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory sequencing controller: access size, FSM state
// and arbitration grant, plus the alignment check used at request time.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } size_t;

   typedef enum logic [2:0] {
      IDLE,
      RD1,
      RD2,
      RESP,
      MERGE,
      WR,
      ERR
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } grant_t;

   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   // Fetches are always word accesses; data accesses must be naturally aligned.
   function automatic logic access_bad(input grant_t     g,
                                       input logic [1:0] a_lo,
                                       input logic [1:0] sz);
      logic bad;
      if (g == FETCH) begin
         bad = (a_lo != 2'b00);
      end else begin
         case (sz)
            2'b00:   bad = 1'b0;
            2'b01:   bad = a_lo[0];
            2'b10:   bad = (a_lo != 2'b00);
            default: bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts/extends sub-word loads and merges
// sub-word store data into a read-back word.
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  size_t       size_i,
   input  logic        unsigned_i,
   input  logic [31:0] word_i,
   input  logic [15:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr_lo_i)
         2'd0: byte_sel = word_i[7:0];
         2'd1: byte_sel = word_i[15:8];
         2'd2: byte_sel = word_i[23:16];
         2'd3: byte_sel = word_i[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      load_o  = word_i;
      merge_o = word_i;
      case (size_i)
         BYTE: begin
            load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            case (addr_lo_i)
               2'd0: merge_o[7:0]   = wdata_i[7:0];
               2'd1: merge_o[15:8]  = wdata_i[7:0];
               2'd2: merge_o[23:16] = wdata_i[7:0];
               2'd3: merge_o[31:24] = wdata_i[7:0];
               default: merge_o = word_i;
            endcase
         end
         HALF: begin
            load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            if (addr_lo_i[1]) merge_o[31:16] = wdata_i;
            else              merge_o[15:0]  = wdata_i;
         end
         default: begin
            load_o  = word_i;
            merge_o = word_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_controller.sv
// Two-port arbiter and access sequencer in front of a registered single-port
// word memory; sub-word stores are done as read-modify-write.
//
// state | meaning
// IDLE  | arbitrate, latch request, load mem_addr
// RD1   | address presented to memory
// RD2   | memory read in flight
// RESP  | read data on mem_data_out, ready pulse for load/fetch
// MERGE | splice store lane into read-back word
// WR    | write strobe and d_ready
// ERR   | ready + err for misaligned/illegal request
module mem_controller
   import mem_ctrl_pkg::*;
#(
   parameter int WORD_ADDR_BITS = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_size,
   input  logic        d_unsigned,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        mem_write_enable,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   state_t                    state_q;
   grant_t                    grant_q;
   grant_t                    last_q;
   logic [1:0]                addr_lo_q;
   size_t                     size_q;
   logic                      uns_q;
   logic                      store_q;
   logic [15:0]               wdata_q;
   logic                      mem_we_q;
   logic [WORD_ADDR_BITS-1:0] mem_addr_q;
   logic [31:0]               mem_data_in_q;
   logic                      if_ready_q;
   logic                      if_err_q;
   logic                      d_ready_q;
   logic                      d_err_q;

   grant_t                    grant_d;
   logic                      req_any;
   logic [1:0]                sel_lo;
   logic [WORD_ADDR_BITS-1:0] sel_idx;
   logic                      sel_bad;
   logic [31:0]               load_word;
   logic [31:0]               merge_word;

   // Byte-address bits above the word index alias and are intentionally dropped.
   logic unused_hi_addr;
   assign unused_hi_addr = ^{if_addr[31:WORD_ADDR_BITS+2], d_addr[31:WORD_ADDR_BITS+2]};

   always_comb begin
      req_any = if_req | d_req;
      if (if_req && d_req) grant_d = (last_q == FETCH) ? DATA : FETCH;
      else if (d_req)      grant_d = DATA;
      else                 grant_d = FETCH;
      sel_lo  = (grant_d == DATA) ? d_addr[1:0] : if_addr[1:0];
      sel_idx = (grant_d == DATA) ? d_addr[WORD_ADDR_BITS+1:2]
                                  : if_addr[WORD_ADDR_BITS+1:2];
      sel_bad = access_bad(grant_d, sel_lo, d_size);
   end

   mem_lane_align u_align (
      .addr_lo_i  (addr_lo_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .word_i     (mem_data_out),
      .wdata_i    (wdata_q),
      .load_o     (load_word),
      .merge_o    (merge_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= FETCH;
         last_q        <= FETCH;
         addr_lo_q     <= 2'b00;
         size_q        <= WORD;
         uns_q         <= 1'b0;
         store_q       <= 1'b0;
         wdata_q       <= '0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
         if_ready_q    <= 1'b0;
         if_err_q      <= 1'b0;
         d_ready_q     <= 1'b0;
         d_err_q       <= 1'b0;
      end else begin
         mem_we_q   <= 1'b0;
         if_ready_q <= 1'b0;
         if_err_q   <= 1'b0;
         d_ready_q  <= 1'b0;
         d_err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_any) begin
                  grant_q    <= grant_d;
                  last_q     <= grant_d;
                  addr_lo_q  <= sel_lo;
                  mem_addr_q <= sel_idx;
                  if (grant_d == DATA) begin
                     size_q  <= (d_size == SIZE_ILLEGAL) ? WORD : size_t'(d_size);
                     uns_q   <= d_unsigned;
                     store_q <= d_we;
                     wdata_q <= d_wdata[15:0];
                  end else begin
                     size_q  <= WORD;
                     uns_q   <= 1'b0;
                     store_q <= 1'b0;
                  end
                  if (sel_bad) begin
                     state_q <= ERR;
                     if (grant_d == DATA) begin
                        d_ready_q <= 1'b1;
                        d_err_q   <= 1'b1;
                     end else begin
                        if_ready_q <= 1'b1;
                        if_err_q   <= 1'b1;
                     end
                  end else if (grant_d == DATA && d_we && d_size == 2'b10) begin
                     state_q       <= WR;
                     mem_data_in_q <= d_wdata;
                     mem_we_q      <= 1'b1;
                     d_ready_q     <= 1'b1;
                  end else begin
                     state_q <= RD1;
                  end
               end
            end
            RD1: state_q <= RD2;
            RD2: begin
               if (store_q) begin
                  state_q <= MERGE;
               end else begin
                  state_q <= RESP;
                  if (grant_q == DATA) d_ready_q  <= 1'b1;
                  else                 if_ready_q <= 1'b1;
               end
            end
            MERGE: begin
               state_q       <= WR;
               mem_data_in_q <= merge_word;
               mem_we_q      <= 1'b1;
               d_ready_q     <= 1'b1;
            end
            RESP:    state_q <= IDLE;
            WR:      state_q <= IDLE;
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_ready         = if_ready_q;
   assign if_err           = if_err_q;
   assign d_ready          = d_ready_q;
   assign d_err            = d_err_q;
   assign if_rdata         = (state_q == RESP && grant_q == FETCH) ? mem_data_out : 32'h0;
   assign d_rdata          = (state_q == RESP && grant_q == DATA)  ? load_word    : 32'h0;
   assign mem_write_enable = mem_we_q;
   assign mem_addr         = {{(32-WORD_ADDR_BITS){1'b0}}, mem_addr_q};
   assign mem_data_in      = mem_data_in_q;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: registered 512x32 memory model, directed vector
// table, arbitration/reset sequences and randomized accesses vs a byte model.
module tb_mem_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic        if_err;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic        d_err;
   logic [31:0] d_rdata;
   logic        mem_write_enable;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_controller #(.WORD_ADDR_BITS(9)) dut (
      .clk              (clk),
      .reset            (reset),
      .if_req           (if_req),
      .if_addr          (if_addr),
      .if_ready         (if_ready),
      .if_err           (if_err),
      .if_rdata         (if_rdata),
      .d_req            (d_req),
      .d_we             (d_we),
      .d_addr           (d_addr),
      .d_size           (d_size),
      .d_unsigned       (d_unsigned),
      .d_wdata          (d_wdata),
      .d_ready          (d_ready),
      .d_err            (d_err),
      .d_rdata          (d_rdata),
      .mem_write_enable (mem_write_enable),
      .mem_addr         (mem_addr),
      .mem_data_in      (mem_data_in),
      .mem_data_out     (mem_data_out)
   );

   // Memory: registered address and registered output, write at the edge.
   logic        mem_clr;
   logic [31:0] mem_arr [0:511];
   logic [8:0]  mem_addr_r;
   always_ff @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 512; i++) mem_arr[i] <= 32'h0;
      end else if (mem_write_enable) begin
         mem_arr[mem_addr[8:0]] <= mem_data_in;
      end
      mem_addr_r   <= mem_addr[8:0];
      mem_data_out <= mem_arr[mem_addr_r];
   end

   // Byte-level reference image of the memory (2 KiB, addresses alias above).
   logic [7:0] ref_b [0:2047];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic xact(input logic f, input logic we, input logic [31:0] a,
                       input logic [1:0] sz, input logic u, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er,
                       output int nwe, output logic [31:0] wa);
      logic ok;
      lat = -1; rd = 32'h0; er = 1'b0; nwe = 0; wa = 32'h0;
      @(posedge clk); #1;
      if (f) begin
         if_req = 1'b1; if_addr = a;
      end else begin
         d_req = 1'b1; d_we = we; d_addr = a; d_size = sz; d_unsigned = u; d_wdata = wd;
      end
      for (int k = 0; k < 20 && lat < 0; k++) begin
         @(negedge clk);
         ok = !(if_ready && d_ready) && (if_ready || if_rdata == 32'h0) &&
              (d_ready || d_rdata == 32'h0) && !(mem_write_enable && (if_err || d_err)) &&
              !(f ? d_ready : if_ready);
         chk("invariant", {31'h0, ok}, 32'h1);
         if (mem_write_enable) begin
            nwe++;
            wa = mem_addr;
         end
         if (f ? if_ready : d_ready) begin
            lat = k;
            rd  = f ? if_rdata : d_rdata;
            er  = f ? if_err : d_err;
         end
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      d_req  = 1'b0;
   endtask

   typedef struct {
      logic        f;
      logic        we;
      logic [31:0] a;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] wd;
      int          lat;
      logic        er;
      logic [31:0] rd;
      int          nwe;
   } vec_t;

   vec_t tbl [16];

   function automatic logic ref_err(input logic f, input logic [31:0] a, input logic [1:0] sz);
      if (f) return a[1:0] != 2'b00;
      if (sz == 2'd3) return 1'b1;
      if (sz == 2'd2) return a[1:0] != 2'b00;
      if (sz == 2'd1) return a[0];
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_read(input logic [10:0] ba, input int nbytes, input logic sext);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_b[ba + 11'(i)]) << (8 * i));
      if (sext && nbytes == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sext && nbytes == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   initial begin
      int          lat, nwe, nb, elat, enwe, ev_k [4];
      logic [31:0] rd, wa, a, wd, erd;
      logic        er, f, we, u, eer, ev_d [4];
      logic [1:0]  sz;
      int          nev;

      reset = 1'b1; mem_clr = 1'b1;
      if_req = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_size = 2'b10; d_unsigned = 1'b0; d_wdata = 32'h0;
      for (int i = 0; i < 2048; i++) ref_b[i] = 8'h00;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_we",   {31'h0, mem_write_enable}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_din",  mem_data_in, 32'h0);
      chk("rst_ready",    {30'h0, if_ready, d_ready}, 32'h0);
      chk("rst_err",      {30'h0, if_err, d_err}, 32'h0);
      chk("rst_rdata",    if_rdata | d_rdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0; mem_clr = 1'b0;

      //            f     we    addr          sz     u     wdata         lat er    rdata         nwe
      tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'hDEADBEEF, 1, 1'b0, 32'h0,        1};
      tbl[1]  = '{1'b0, 1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0,        3, 1'b0, 32'hDEADBEEF, 0};
      tbl[2]  = '{1'b0, 1'b1, 32'h0000_0011, 2'd0, 1'b0, 32'h0000_00A5, 4, 1'b0, 32'h0,       1};
      tbl[3]  = '{1'b0, 1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0,        3, 1'b0, 32'hDEADA5EF, 0};
      tbl[4]  = '{1'b0, 1'b0, 32'h0000_0011, 2'd0, 1'b0, 32'h0,        3, 1'b0, 32'hFFFFFFA5, 0};
      tbl[5]  = '{1'b0, 1'b0, 32'h0000_0011, 2'd0, 1'b1, 32'h0,        3, 1'b0, 32'h000000A5, 0};
      tbl[6]  = '{1'b0, 1'b0, 32'h0000_0012, 2'd1, 1'b0, 32'h0,        3, 1'b0, 32'hFFFFDEAD, 0};
      tbl[7]  = '{1'b0, 1'b1, 32'h0000_0010, 2'd1, 1'b1, 32'hFFFF1234, 4, 1'b0, 32'h0,        1};
      tbl[8]  = '{1'b0, 1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0,        3, 1'b0, 32'hDEAD1234, 0};
      tbl[9]  = '{1'b0, 1'b0, 32'h0000_0013, 2'd2, 1'b0, 32'h0,        1, 1'b1, 32'h0,        0};
      tbl[10] = '{1'b0, 1'b1, 32'h0000_0011, 2'd1, 1'b0, 32'h0000_5555, 1, 1'b1, 32'h0,       0};
      tbl[11] = '{1'b0, 1'b0, 32'h0000_0010, 2'd3, 1'b0, 32'h0,        1, 1'b1, 32'h0,        0};
      tbl[12] = '{1'b0, 1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0,        3, 1'b0, 32'hDEAD1234, 0};
      tbl[13] = '{1'b0, 1'b0, 32'hFF00_0810, 2'd2, 1'b0, 32'h0,        3, 1'b0, 32'hDEAD1234, 0};
      tbl[14] = '{1'b1, 1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0,        3, 1'b0, 32'hDEAD1234, 0};
      tbl[15] = '{1'b1, 1'b0, 32'h0000_0002, 2'd2, 1'b0, 32'h0,        1, 1'b1, 32'h0,        0};

      foreach (tbl[i]) begin
         xact(tbl[i].f, tbl[i].we, tbl[i].a, tbl[i].sz, tbl[i].u, tbl[i].wd, lat, rd, er, nwe, wa);
         chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
         chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].er});
         chk($sformatf("vec%0d_nwe", i), nwe, tbl[i].nwe);
         if (!tbl[i].er && !(tbl[i].we && !tbl[i].f))
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
         if (tbl[i].nwe != 0)
            chk($sformatf("vec%0d_waddr", i), wa, {23'h0, tbl[i].a[10:2]});
      end

      // Both ports requesting from reset and held: data, fetch, data, fetch.
      @(posedge clk); #1;
      reset = 1'b1;
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 2'd2; d_unsigned = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      nev = 0;
      for (int k = 0; k < 30 && nev < 4; k++) begin
         @(negedge clk);
         if (if_ready && d_ready) chk("tie_coincide", 32'h1, 32'h0);
         if (if_ready || d_ready) begin
            ev_k[nev] = k;
            ev_d[nev] = d_ready;
            nev++;
         end
      end
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0;
      chk("tie_events", nev, 4);
      for (int i = 0; i < nev; i++) begin
         chk($sformatf("tie%0d_cycle", i), ev_k[i], 3 + 4 * i);
         chk($sformatf("tie%0d_grant_data", i), {31'h0, ev_d[i]}, {31'h0, (i % 2) == 0});
      end

      // Reset during RD2 of a byte store: dropped with no write and no ready.
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_size = 2'd0; d_wdata = 32'h77;
      nwe = 0; nev = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (mem_write_enable) nwe++;
         if (d_ready || if_ready) nev++;
         @(posedge clk); #1;
         if (k == 1) reset = 1'b1;
      end
      reset = 1'b0; d_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk("midrst_mem_addr", mem_addr, 32'h0);
            chk("midrst_rdata", d_rdata, 32'h0);
         end
         if (mem_write_enable) nwe++;
         if (d_ready || if_ready) nev++;
      end
      chk("midrst_no_write", nwe, 0);
      chk("midrst_no_ready", nev, 0);
      xact(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, lat, rd, er, nwe, wa);
      chk("midrst_load_lat", lat, 3);
      chk("midrst_word", rd, 32'hDEAD1234);

      // Randomized accesses against the byte-level model, starting from zeroed memory.
      @(posedge clk); #1;
      mem_clr = 1'b1;
      @(posedge clk); #1;
      mem_clr = 1'b0;
      for (int n = 0; n < 300; n++) begin
         f  = ($urandom_range(0, 3) == 0);
         we = f ? 1'b0 : $urandom_range(0, 1) == 1;
         sz = 2'($urandom_range(0, 3));
         u  = $urandom_range(0, 1) == 1;
         wd = $urandom;
         a  = ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 47));
         eer = ref_err(f, a, sz);
         nb  = (f || sz == 2'd2) ? 4 : (sz == 2'd1 ? 2 : 1);
         if (eer)                  elat = 1;
         else if (f || !we)        elat = 3;
         else if (sz == 2'd2)      elat = 1;
         else                      elat = 4;
         enwe = (!eer && we) ? 1 : 0;
         erd  = ref_read(a[10:0], nb, !f && !u);
         xact(f, we, a, sz, u, wd, lat, rd, er, nwe, wa);
         chk($sformatf("rnd%0d_lat", n), lat, elat);
         chk($sformatf("rnd%0d_err", n), {31'h0, er}, {31'h0, eer});
         chk($sformatf("rnd%0d_nwe", n), nwe, enwe);
         if (!eer && !we) chk($sformatf("rnd%0d_rdata", n), rd, erd);
         if (enwe != 0) begin
            chk($sformatf("rnd%0d_waddr", n), wa, {23'h0, a[10:2]});
            for (int i = 0; i < nb; i++) ref_b[a[10:0] + 11'(i)] = wd[8*i +: 8];
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_controller.md
# mem_controller

Sequencing controller and two-port arbiter placed in front of the 512×32 word-wide `memory` block. It shares the single memory port between the instruction-fetch path and the load/store path. It adds sub-word loads with sign/zero extension. Because the array only has a full-word write enable, it performs byte/halfword stores as read-modify-write sequences. All memory-side signals are driven from registers.

## Interface
- `WORD_ADDR_BITS`, 9: width of the word index driven to memory; the index is byte address `[WORD_ADDR_BITS+1:2]`, and higher address bits are ignored (aliasing).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `if_req` input 1: fetch request; the requester holds it and `if_addr` stable until `if_ready`.
- `if_addr` input 32: fetch byte address; always a word access.
- `if_ready` output 1: one-cycle completion pulse.
- `if_err` output 1: misaligned fetch; valid only with `if_ready`.
- `if_rdata` output 32: fetched word; valid only with `if_ready`, otherwise 0.
- `d_req` input 1: data request; the requester holds it and all `d_*` inputs stable until `d_ready`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input 32: data byte address.
- `d_size` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `d_unsigned` input 1: selects zero-extension for loads.
- `d_wdata` input 32: store data; the low byte/half is used for sub-word stores.
- `d_ready` output 1: one-cycle completion pulse.
- `d_err` output 1: misaligned or illegal access; valid only with `d_ready`.
- `d_rdata` output 32: extended load data; valid only with `d_ready`, otherwise 0.
- `mem_write_enable` output 1: to memory `write_enable`.
- `mem_addr` output 32: to memory `addr`; the upper bits are 0.
- `mem_data_in` output 32: to memory `data_in`.
- `mem_data_out` input 32: from memory `data_out`.

## Operation
- **Memory model:**
  - Both the address and `q` are registered on `clk`.
  - For a read, `mem_addr` driven in cycle N gives `mem_data_out` valid in cycle N+2.
  - A write commits at the edge that ends the cycle in which `mem_write_enable` is 1.
- **FSM states:** IDLE, RD1, RD2, RESP, MERGE, WR, ERR.
- **IDLE:**
  - Samples requests and grants one.
  - Latches the grant, address fields and store data into registers, and loads `mem_addr` with the word index.
- **Arbitration:**
  - A lone request wins.
  - If both requests are present, the requester not granted last wins.
  - The last-grant register resets to "fetch", so data wins the first tie.
- **Transitions from IDLE:**
  - Misaligned or illegal access (fetch with `addr[1:0]`≠0; data half with `addr[0]`=1; data word with `addr[1:0]`≠0; `d_size`=11) → ERR.
  - Load or fetch → RD1.
  - Word store → WR, with `mem_data_in`=`d_wdata`.
  - Sub-word store → RD1.
- **Read path:**
  - RD1 → RD2.
  - RD2 → RESP for a load or fetch; RD2 → MERGE for a sub-word store.
- **RESP:**
  - Asserts the granted `ready`.
  - Drives `rdata` from `mem_data_out`.
  - → IDLE.
- **MERGE:**
  - Registers into `mem_data_in` the word `mem_data_out` with the addressed lane replaced.
  - Byte stores replace lane `addr[1:0]`; half stores replace lane `addr[1]`.
  - Byte order is little-endian.
  - → WR.
- **WR:**
  - `mem_write_enable`=1 for exactly this cycle.
  - Asserts `d_ready`.
  - → IDLE.
- **ERR:**
  - Asserts the granted `ready` and `err`.
  - Never drives `mem_write_enable`.
  - → IDLE.
- **Load extraction:**
  - Byte loads take lane `addr[1:0]`; half loads take lane `addr[1]`.
  - The result is sign-extended unless `d_unsigned`; word loads pass through.
  - Fetches are never extended.
- **Reset:**
  - Next state is IDLE.
  - `mem_write_enable`, `mem_addr`, `mem_data_in`, both `ready`, both `err` and both `rdata` are 0.
  - The last grant is set to fetch.
  - An in-flight request is dropped with no `ready` and no write; the requester must re-present it.

## Timing
- All latencies are counted from cycle 0, the first IDLE cycle in which the request is visible.
- Load or fetch: `ready` in cycle 3, then IDLE in cycle 4.
- Word store: `ready` and the write in cycle 1.
- Sub-word store: `ready` and the write in cycle 4.
- Error: `ready`+`err` in cycle 1.
- After `ready`, the controller returns to IDLE the next cycle, so a held request re-arbitrates there (back-to-back accesses).
- A requester may change its inputs or drop `req` only in the cycle after its `ready`.
- At most one `ready` is high in any cycle.
- `mem_addr` and `mem_data_in` hold their values outside the cycles in which they are loaded.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the `size_t` enum (BYTE, HALF, WORD),
  - the `state_t` enum,
  - the `grant_t` enum (FETCH, DATA).
- One combinational sub-module, `mem_lane_align`, performs load extraction/extension and store merge, driven by `addr[1:0]`, size and unsigned.

## Test plan
- Word store 0xDEADBEEF to 0x10: `d_ready` and `mem_write_enable` in cycle 1 with `mem_addr`=4. A following word load from 0x10 → `d_ready` in cycle 3 with `d_rdata`=0xDEADBEEF.
- Byte store 0xA5 to 0x11 over that word: `d_ready` in cycle 4, memory word becomes 0xDEADA5EF. Signed byte load from 0x11 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Signed half load from 0x12 → 0xFFFFDEAD. Unsigned half store 0x1234 to 0x10 → word 0xDEAD1234.
- `if_req` and `d_req` both asserted from reset and held: grants are data, fetch, data, fetch; the `ready` pulses are 4 cycles apart and never coincide.
- Word load from 0x13 → `d_ready`=`d_err`=1 in cycle 1. Half store to 0x11 → error with memory unchanged and `mem_write_enable` never high. Fetch from 0x02 → `if_err`.
- `reset` asserted during RD2 of a byte store to 0x10 → no `mem_write_enable`, no `d_ready`, IDLE next cycle, memory word unchanged.
